packet_sender: RTL and testbench

- Avalon-ST packet transmitter. It is the traffic source that feeds the packet classifier's sink and drives classifier test and loopback setups.
- Software uses an Avalon-MM slave to load data words into an internal circular buffer, set packet length, empty and channel, then issue a start command.
- The block then emits one Avalon-ST packet with SOP/EOP framing and ready backpressure.

---
 rtl/packet_sender_pkg.sv | 24 ++
 rtl/packet_sender_buf.sv | 56 +++++
 rtl/packet_sender.sv | 168 ++++++++++++++++
 tb/tb_packet_sender.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/packet_sender_pkg.sv
// Shared register map, control/status bit positions and FSM state encoding
// for the Avalon-ST packet sender.
package packet_sender_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_LEN     = 3'd1;
  localparam logic [2:0] ADDR_EMPTY   = 3'd2;
  localparam logic [2:0] ADDR_CHAN    = 3'd3;
  localparam logic [2:0] ADDR_DATA_LO = 3'd4;
  localparam logic [2:0] ADDR_DATA_HI = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;
  localparam logic [2:0] ADDR_PKT_CNT = 3'd7;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_CLR_ERR_BIT = 2;
  localparam int CTRL_BUSY_BIT    = 0;

  localparam int STAT_OVF_BIT       = 16;
  localparam int STAT_START_ERR_BIT = 17;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

endpackage

// File: rtl/packet_sender_buf.sv
// Circular word buffer: read data is the head entry, combinationally.
// Pushes into a full buffer and pops from an empty one are ignored.
module packet_sender_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_fill
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_fill;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_fill == CW'(DEPTH));
  assign o_empty = (r_fill == '0);
  assign o_fill  = r_fill;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/packet_sender.sv
// Avalon-MM programmed Avalon-ST packet source: software fills the buffer,
// sets LEN/EMPTY/CHAN and issues START; one packet is sent under ready backpressure.
module packet_sender
  import packet_sender_pkg::*;
#(
  parameter int  AMM_DWIDTH    = 32,
  parameter int  AST_DWIDTH    = 64,
  parameter int  CHANNEL_WIDTH = 1,
  parameter int  BUF_DEPTH     = 16,
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8),
  localparam int CNT_WIDTH     = $clog2(BUF_DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [2:0]               i_amm_address,
  input  logic                     i_amm_write,
  input  logic [AMM_DWIDTH-1:0]    i_amm_writedata,
  input  logic                     i_amm_read,
  output logic [AMM_DWIDTH-1:0]    o_amm_readdata,
  output logic                     o_amm_waitrequest,
  input  logic                     i_ast_ready,
  output logic [AST_DWIDTH-1:0]    o_ast_data,
  output logic                     o_ast_valid,
  output logic                     o_ast_startofpacket,
  output logic                     o_ast_endofpacket,
  output logic [EMPTY_WIDTH-1:0]   o_ast_empty,
  output logic [CHANNEL_WIDTH-1:0] o_ast_channel
);

  state_t                   r_state;
  logic [CNT_WIDTH-1:0]     r_len, r_lat_len, r_beat;
  logic [EMPTY_WIDTH-1:0]   r_empty, r_lat_empty, r_ast_empty;
  logic [CHANNEL_WIDTH-1:0] r_chan, r_ast_chan;
  logic [AMM_DWIDTH-1:0]    r_data_lo, r_pkt_cnt, r_readdata;
  logic                     r_ovf, r_start_err;
  logic                     r_valid, r_sop, r_eop;

  logic                     w_wr_ctrl, w_start, w_start_ok, w_flush, w_clr_err;
  logic                     w_push, w_accept, w_buf_full, w_buf_empty, w_last_nxt;
  logic [CNT_WIDTH-1:0]     w_fill, w_beat_nxt;
  logic [AST_DWIDTH-1:0]    w_buf_rdata;
  logic [AMM_DWIDTH-1:0]    w_rdmux;

  assign w_wr_ctrl  = i_amm_write & (i_amm_address == ADDR_CTRL);
  assign w_start    = w_wr_ctrl & i_amm_writedata[CTRL_START_BIT];
  assign w_clr_err  = w_wr_ctrl & i_amm_writedata[CTRL_CLR_ERR_BIT];
  assign w_start_ok = w_start & (r_state == IDLE) & (r_len != '0) & (r_len <= w_fill) & ~w_buf_empty;
  // A successful START wins over a FLUSH in the same write so the packet data survives.
  assign w_flush    = w_wr_ctrl & i_amm_writedata[CTRL_FLUSH_BIT] & (r_state == IDLE) & ~w_start_ok;
  assign w_push     = i_amm_write & (i_amm_address == ADDR_DATA_HI);
  assign w_accept   = r_valid & i_ast_ready;
  assign w_beat_nxt = r_beat + CNT_WIDTH'(1);
  assign w_last_nxt = (w_beat_nxt == r_lat_len - CNT_WIDTH'(1));

  packet_sender_buf #(.WIDTH(AST_DWIDTH), .DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (srst_i),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_flush (w_flush),
    .i_wdata ({i_amm_writedata, r_data_lo}),
    .o_rdata (w_buf_rdata),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_fill  (w_fill)
  );

  always_comb begin
    w_rdmux = '0;
    case (i_amm_address)
      ADDR_CTRL:    w_rdmux[CTRL_BUSY_BIT] = (r_state == SEND);
      ADDR_LEN:     w_rdmux[CNT_WIDTH-1:0] = r_len;
      ADDR_EMPTY:   w_rdmux[EMPTY_WIDTH-1:0] = r_empty;
      ADDR_CHAN:    w_rdmux[CHANNEL_WIDTH-1:0] = r_chan;
      ADDR_STATUS: begin
        w_rdmux[CNT_WIDTH-1:0]     = w_fill;
        w_rdmux[STAT_OVF_BIT]       = r_ovf;
        w_rdmux[STAT_START_ERR_BIT] = r_start_err;
      end
      ADDR_PKT_CNT: w_rdmux = r_pkt_cnt;
      default:      w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_len       <= '0;
      r_empty     <= '0;
      r_chan      <= '0;
      r_data_lo   <= '0;
      r_pkt_cnt   <= '0;
      r_readdata  <= '0;
      r_ovf       <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      if (i_amm_write) begin
        case (i_amm_address)
          ADDR_LEN:     r_len     <= i_amm_writedata[CNT_WIDTH-1:0];
          ADDR_EMPTY:   r_empty   <= i_amm_writedata[EMPTY_WIDTH-1:0];
          ADDR_CHAN:    r_chan    <= i_amm_writedata[CHANNEL_WIDTH-1:0];
          ADDR_DATA_LO: r_data_lo <= i_amm_writedata;
          default: ;
        endcase
      end
      if (w_clr_err) begin
        r_ovf       <= 1'b0;
        r_start_err <= 1'b0;
      end
      if (w_push & w_buf_full)                       r_ovf       <= 1'b1;
      if (w_start & (r_state == IDLE) & ~w_start_ok) r_start_err <= 1'b1;
      if (w_accept & r_eop)                          r_pkt_cnt   <= r_pkt_cnt + AMM_DWIDTH'(1);
      if (i_amm_read)                                r_readdata  <= w_rdmux;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_ast_empty <= '0;
      r_ast_chan  <= '0;
      r_lat_len   <= '0;
      r_lat_empty <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start_ok) begin
          r_state     <= SEND;
          r_valid     <= 1'b1;
          r_sop       <= 1'b1;
          r_eop       <= (r_len == CNT_WIDTH'(1));
          r_ast_empty <= (r_len == CNT_WIDTH'(1)) ? r_empty : '0;
          r_ast_chan  <= r_chan;
          r_lat_len   <= r_len;
          r_lat_empty <= r_empty;
          r_beat      <= '0;
        end
        SEND: if (w_accept) begin
          if (r_eop) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_ast_empty <= '0;
            r_ast_chan  <= '0;
          end else begin
            r_beat      <= w_beat_nxt;
            r_sop       <= 1'b0;
            r_eop       <= w_last_nxt;
            r_ast_empty <= w_last_nxt ? r_lat_empty : '0;
          end
        end
      endcase
    end
  end

  assign o_amm_readdata      = r_readdata;
  assign o_amm_waitrequest   = 1'b0;
  assign o_ast_data          = r_valid ? w_buf_rdata : '0;
  assign o_ast_valid         = r_valid;
  assign o_ast_startofpacket = r_sop;
  assign o_ast_endofpacket   = r_eop;
  assign o_ast_empty         = r_ast_empty;
  assign o_ast_channel       = r_ast_chan;

endmodule

// File: tb/tb_packet_sender.sv
// Directed bench for packet_sender: register access, framing, backpressure,
// start errors, overflow with pointer wrap, single-beat packets and async reset.
module tb_packet_sender;

  logic        clk;
  logic        srst;
  logic [2:0]  amm_address;
  logic        amm_write;
  logic [31:0] amm_writedata;
  logic        amm_read;
  logic [31:0] amm_readdata;
  logic        amm_waitrequest;
  logic        ast_ready;
  logic [63:0] ast_data;
  logic        ast_valid;
  logic        ast_sop;
  logic        ast_eop;
  logic [2:0]  ast_empty;
  logic [0:0]  ast_channel;

  int n_vec = 0;
  int n_err = 0;

  packet_sender dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .i_amm_address       (amm_address),
    .i_amm_write         (amm_write),
    .i_amm_writedata     (amm_writedata),
    .i_amm_read          (amm_read),
    .o_amm_readdata      (amm_readdata),
    .o_amm_waitrequest   (amm_waitrequest),
    .i_ast_ready         (ast_ready),
    .o_ast_data          (ast_data),
    .o_ast_valid         (ast_valid),
    .o_ast_startofpacket (ast_sop),
    .o_ast_endofpacket   (ast_eop),
    .o_ast_empty         (ast_empty),
    .o_ast_channel       (ast_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic amm_wr(input logic [2:0] a, input logic [31:0] d);
    amm_address = a; amm_writedata = d; amm_write = 1'b1;
    @(negedge clk);
    amm_write = 1'b0;
  endtask

  task automatic amm_rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    amm_address = a; amm_read = 1'b1;
    @(negedge clk);
    amm_read = 1'b0;
    check(tag, {96'd0, amm_readdata}, {96'd0, exp});
  endtask

  task automatic push(input logic [63:0] w);
    amm_wr(3'd4, w[31:0]);
    amm_wr(3'd5, w[63:32]);
  endtask

  // Observed beat is {valid, sop, eop, empty, channel, data}.
  task automatic beat_chk(input string tag, input logic v, input logic s, input logic e,
                          input logic [2:0] emp, input logic ch, input logic [63:0] d);
    check(tag, {57'd0, ast_valid, ast_sop, ast_eop, ast_empty, ast_channel, ast_data},
               {57'd0, v, s, e, emp, ch, d});
  endtask

  function automatic logic [63:0] w4(input int i);
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
  endfunction

  logic [63:0] pkt3 [3];
  int          exp_idx [6];
  logic        rdy_pat [6];

  initial begin
    pkt3[0] = 64'h1111_1111_1111_1111;
    pkt3[1] = 64'h2222_2222_2222_2222;
    pkt3[2] = 64'h3333_3333_3333_3333;
    exp_idx = '{0, 1, 1, 1, 2, 2};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    srst = 1'b1; amm_address = '0; amm_write = 1'b0; amm_writedata = '0;
    amm_read = 1'b0; ast_ready = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);

    // Reset state
    beat_chk("reset_ast", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    check("reset_waitreq", {127'd0, amm_waitrequest}, 128'd0);
    amm_rd_chk("reset_status", 3'd6, 32'h0);
    amm_rd_chk("reset_pktcnt", 3'd7, 32'h0);
    amm_rd_chk("reset_ctrl", 3'd0, 32'h0);

    // Basic 3-beat packet, ready held high
    for (int i = 0; i < 3; i++) push(pkt3[i]);
    amm_wr(3'd1, 32'd3);
    amm_wr(3'd2, 32'd5);
    amm_wr(3'd3, 32'd1);
    amm_rd_chk("len_readback", 3'd1, 32'd3);
    amm_rd_chk("fill_3", 3'd6, 32'd3);
    amm_wr(3'd0, 32'h1);
    beat_chk("p1_beat0", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, pkt3[0]);
    @(negedge clk);
    beat_chk("p1_beat1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, pkt3[1]);
    @(negedge clk);
    beat_chk("p1_beat2", 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, pkt3[2]);
    @(negedge clk);
    beat_chk("p1_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    amm_rd_chk("p1_pktcnt", 3'd7, 32'd1);
    amm_rd_chk("p1_status", 3'd6, 32'd0);

    // Same packet under backpressure
    for (int i = 0; i < 3; i++) push(pkt3[i]);
    amm_wr(3'd0, 32'h1);
    for (int c = 0; c < 6; c++) begin
      beat_chk($sformatf("bp_cyc%0d", c), 1'b1, exp_idx[c] == 0, exp_idx[c] == 2,
               (exp_idx[c] == 2) ? 3'd5 : 3'd0, 1'b1, pkt3[exp_idx[c]]);
      ast_ready = rdy_pat[c];
      @(negedge clk);
    end
    beat_chk("bp_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    ast_ready = 1'b1;
    amm_rd_chk("bp_pktcnt", 3'd7, 32'd2);

    // Overflow: 17 pushes into 16 entries, pointers start mid-buffer so reads wrap
    for (int i = 0; i < 17; i++) push(w4(i));
    amm_rd_chk("ovf_status", 3'd6, 32'h0001_0010);
    amm_wr(3'd1, 32'd16);
    amm_wr(3'd2, 32'd7);
    amm_wr(3'd3, 32'd0);
    amm_wr(3'd0, 32'h1);
    for (int i = 0; i < 16; i++) begin
      beat_chk($sformatf("ovf_beat%0d", i), 1'b1, i == 0, i == 15,
               (i == 15) ? 3'd7 : 3'd0, 1'b0, w4(i));
      @(negedge clk);
    end
    beat_chk("ovf_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    amm_rd_chk("ovf_sticky", 3'd6, 32'h0001_0000);
    amm_wr(3'd0, 32'h4);
    amm_rd_chk("ovf_cleared", 3'd6, 32'h0);
    amm_rd_chk("ovf_pktcnt", 3'd7, 32'd3);

    // START with LEN above fill is refused
    push(64'hDEAD_BEEF_0000_0001);
    push(64'hDEAD_BEEF_0000_0002);
    amm_wr(3'd1, 32'd4);
    amm_wr(3'd0, 32'h1);
    beat_chk("serr_novalid", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    amm_rd_chk("serr_status", 3'd6, 32'h0002_0002);
    amm_wr(3'd0, 32'h4);
    amm_rd_chk("serr_cleared", 3'd6, 32'h0000_0002);
    amm_wr(3'd0, 32'h2);
    amm_rd_chk("flush_status", 3'd6, 32'h0);

    // LEN=1: SOP and EOP on the same beat, busy visible while held
    push(64'hCAFE_0000_1234_5678);
    amm_wr(3'd1, 32'd1);
    amm_wr(3'd2, 32'd3);
    amm_wr(3'd3, 32'd1);
    ast_ready = 1'b0;
    amm_wr(3'd0, 32'h1);
    beat_chk("len1_beat", 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 64'hCAFE_0000_1234_5678);
    amm_rd_chk("len1_busy", 3'd0, 32'h1);
    beat_chk("len1_hold", 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 64'hCAFE_0000_1234_5678);
    ast_ready = 1'b1;
    @(negedge clk);
    beat_chk("len1_idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    amm_rd_chk("len1_notbusy", 3'd0, 32'h0);
    amm_rd_chk("len1_pktcnt", 3'd7, 32'd4);

    // Asynchronous reset during beat 1 of a 3-beat packet
    for (int i = 0; i < 3; i++) push(pkt3[i]);
    amm_wr(3'd1, 32'd3);
    amm_wr(3'd0, 32'h1);
    beat_chk("rst_beat0", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, pkt3[0]);
    @(negedge clk);
    beat_chk("rst_beat1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, pkt3[1]);
    #2 srst = 1'b1;
    #1 beat_chk("rst_async", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd0);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    amm_rd_chk("rst_status", 3'd6, 32'h0);
    amm_rd_chk("rst_pktcnt", 3'd7, 32'h0);
    amm_rd_chk("rst_len", 3'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
